addex_acc: RTL and testbench



---
 rtl/addex_pkg.sv | 19 +
 rtl/addex_acc_if.sv | 33 +++
 rtl/sat_add.sv | 23 ++
 rtl/addex_acc.sv | 116 +++++++++++
 tb/tb_addex_acc.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/addex_pkg.sv
// addex_pkg: shared widths and state encoding for the addex adder family.
// Revision: 1.0
`default_nettype none

package addex_pkg;

    localparam int QW_DEF = 4;
    localparam int SW_DEF = 8;
    localparam int LW_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/addex_acc_if.sv
// addex_acc_if: sample stream, frame control and result readout of addex_acc.
// Revision: 1.0
`default_nettype none

interface addex_acc_if #(
    parameter int SW = 8,
    parameter int QW = 4,
    parameter int LW = 5
);
    logic          START;
    logic [LW-1:0] LEN;
    logic [QW-1:0] QIN;
    logic          QVALID;
    logic          QREADY;
    logic [SW-1:0] SUM;
    logic          OVF;
    logic [LW-1:0] CNT;
    logic          DONE;
    logic          BUSY;
    logic          ACK;

    modport master (
        output START, LEN, QIN, QVALID, ACK,
        input  QREADY, SUM, OVF, CNT, DONE, BUSY
    );

    modport slave (
        input  START, LEN, QIN, QVALID, ACK,
        output QREADY, SUM, OVF, CNT, DONE, BUSY
    );
endinterface

`default_nettype wire

// File: rtl/sat_add.sv
// sat_add: unsigned saturating adder, SW-bit accumulator plus QW-bit operand.
// Revision: 1.0
`default_nettype none

module sat_add #(
    parameter int SW = 8,
    parameter int QW = 4
) (
    input  wire logic [SW-1:0] a_i,
    input  wire logic [QW-1:0] b_i,
    output logic      [SW-1:0] sum_o,
    output logic               ovf_o
);

    logic [SW:0] w_full;

    assign w_full = {1'b0, a_i} + {{(SW + 1 - QW){1'b0}}, b_i};
    assign ovf_o  = w_full[SW];
    assign sum_o  = w_full[SW] ? {SW{1'b1}} : w_full[SW-1:0];

endmodule

`default_nettype wire

// File: rtl/addex_acc.sv
// addex_acc: accumulates a programmed number of addex samples into a
// saturating total and holds the result until acknowledged. Revision: 1.0
`default_nettype none

module addex_acc
    import addex_pkg::*;
#(
    parameter int SW = SW_DEF,
    parameter int QW = QW_DEF,
    parameter int LW = LW_DEF
) (
    input wire logic  CK,
    input wire logic  RES,
    addex_acc_if.slave bus
);

    state_t        state_q;
    logic [LW-1:0] len_q;
    logic [SW-1:0] sum_q;
    logic          ovf_q;
    logic [LW-1:0] cnt_q;
    logic          qready_q;
    logic          done_q;
    logic          busy_q;

    logic [SW-1:0] sum_d;
    logic          ovf_d;
    logic [LW-1:0] cnt_d;
    logic          w_start;

    sat_add #(
        .SW (SW),
        .QW (QW)
    ) u_sat_add (
        .a_i   (sum_q),
        .b_i   (bus.QIN),
        .sum_o (sum_d),
        .ovf_o (ovf_d)
    );

    assign cnt_d   = cnt_q + 1'b1;
    // START is honoured in IDLE, or in HOLD only alongside ACK (restart).
    assign w_start = bus.START &
                     ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.ACK));

    always_ff @(posedge CK) begin
        if (RES) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            sum_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            qready_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else if (w_start) begin
            len_q  <= bus.LEN;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (bus.LEN == '0) begin
                state_q  <= ST_HOLD;
                qready_q <= 1'b0;
                done_q   <= 1'b1;
            end else begin
                state_q  <= ST_ACC;
                qready_q <= 1'b1;
                done_q   <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    qready_q <= 1'b0;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                end
                ST_ACC: begin
                    if (bus.QVALID) begin
                        sum_q <= sum_d;
                        ovf_q <= ovf_q | ovf_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == len_q) begin
                            state_q  <= ST_HOLD;
                            qready_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.ACK) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    qready_q <= 1'b0;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.QREADY = qready_q;
    assign bus.SUM    = sum_q;
    assign bus.OVF    = ovf_q;
    assign bus.CNT    = cnt_q;
    assign bus.DONE   = done_q;
    assign bus.BUSY   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_addex_acc.sv
// tb_addex_acc: directed frames against a frame-level reference model.
// Revision: 1.0
`default_nettype none

module tb_addex_acc;

    logic CK  = 1'b0;
    logic RES = 1'b1;

    addex_acc_if #(.SW(8), .QW(4), .LW(5)) bus ();

    addex_acc #(.SW(8), .QW(4), .LW(5)) dut (
        .CK  (CK),
        .RES (RES),
        .bus (bus)
    );

    always #5 CK = ~CK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Frame-level model: phase 0=no frame, 1=collecting, 2=result held.
    int m_phase = 0;
    int m_len   = 0;
    int m_sum   = 0;
    int m_ovf   = 0;
    int m_cnt   = 0;

    always @(posedge CK) begin
        if (RES) begin
            m_phase = 0; m_sum = 0; m_ovf = 0; m_cnt = 0;
        end else if (bus.START && (m_phase == 0 || (m_phase == 2 && bus.ACK))) begin
            m_len = int'(bus.LEN);
            m_sum = 0; m_ovf = 0; m_cnt = 0;
            m_phase = (m_len == 0) ? 2 : 1;
        end else if (m_phase == 1 && bus.QVALID) begin
            m_sum = m_sum + int'(bus.QIN);
            if (m_sum > 255) begin
                m_sum = 255;
                m_ovf = 1;
            end
            m_cnt = m_cnt + 1;
            if (m_cnt == m_len) m_phase = 2;
        end else if (m_phase == 2 && bus.ACK) begin
            m_phase = 0;
        end
        #1;
        chk("cyc_sum",    int'(bus.SUM),    m_sum);
        chk("cyc_ovf",    int'(bus.OVF),    m_ovf);
        chk("cyc_cnt",    int'(bus.CNT),    m_cnt);
        chk("cyc_qready", int'(bus.QREADY), int'(m_phase == 1));
        chk("cyc_done",   int'(bus.DONE),   int'(m_phase == 2));
        chk("cyc_busy",   int'(bus.BUSY),   int'(m_phase != 0));
    end

    // Inputs change on the falling edge; outputs are Moore so they can be
    // checked right after a drive returns.
    task automatic drive(input logic st, input int len, input int q,
                         input logic qv, input logic ack);
        @(negedge CK);
        bus.START  = st;
        bus.LEN    = 5'(len);
        bus.QIN    = 4'(q);
        bus.QVALID = qv;
        bus.ACK    = ack;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    int stall_v [6] = '{1, 0, 0, 1, 0, 1};
    int stall_q [6] = '{2, 0, 0, 4, 0, 6};

    initial begin
        bus.START = 1'b0; bus.LEN = '0; bus.QIN = '0; bus.QVALID = 1'b0; bus.ACK = 1'b0;
        idle();
        idle();
        chk("rst_sum",  int'(bus.SUM),  0);
        chk("rst_busy", int'(bus.BUSY), 0);
        chk("rst_done", int'(bus.DONE), 0);
        RES = 1'b0;

        // Basic frame
        drive(1'b1, 4, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 3, 1'b1, 1'b0);
        chk("basic_qready", int'(bus.QREADY), 1);
        drive(1'b0, 0, 5, 1'b1, 1'b0);
        drive(1'b0, 0, 7, 1'b1, 1'b0);
        drive(1'b0, 0, 1, 1'b1, 1'b0);
        chk("basic_not_done", int'(bus.DONE), 0);
        idle();
        chk("basic_done", int'(bus.DONE), 1);
        chk("basic_sum",  int'(bus.SUM),  16);
        chk("basic_cnt",  int'(bus.CNT),  4);
        chk("basic_ovf",  int'(bus.OVF),  0);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        idle();
        chk("ack_done", int'(bus.DONE), 0);
        chk("ack_busy", int'(bus.BUSY), 0);

        // Stall
        drive(1'b1, 3, 0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 0, stall_q[i], stall_v[i] != 0, 1'b0);
            chk("stall_not_done", int'(bus.DONE), 0);
        end
        idle();
        chk("stall_done", int'(bus.DONE), 1);
        chk("stall_sum",  int'(bus.SUM),  12);
        chk("stall_cnt",  int'(bus.CNT),  3);
        drive(1'b0, 0, 0, 1'b0, 1'b1);

        // Saturation: 17 x 15 = 255 exactly, the 18th sample overflows
        drive(1'b1, 31, 0, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) begin
            drive(1'b0, 0, 15, 1'b1, 1'b0);
            if (i == 17) begin
                chk("sat17_sum", int'(bus.SUM), 255);
                chk("sat17_ovf", int'(bus.OVF), 0);
            end
            if (i == 18) chk("sat18_ovf", int'(bus.OVF), 1);
        end
        idle();
        chk("sat_sum",  int'(bus.SUM),  255);
        chk("sat_ovf",  int'(bus.OVF),  1);
        chk("sat_cnt",  int'(bus.CNT),  31);
        chk("sat_done", int'(bus.DONE), 1);
        drive(1'b0, 0, 0, 1'b0, 1'b1);

        // Empty frame, then back-to-back restart from HOLD
        drive(1'b1, 0, 0, 1'b0, 1'b0);
        idle();
        chk("empty_done",   int'(bus.DONE),   1);
        chk("empty_sum",    int'(bus.SUM),    0);
        chk("empty_qready", int'(bus.QREADY), 0);
        drive(1'b1, 2, 0, 1'b0, 1'b1);
        drive(1'b0, 0, 9, 1'b1, 1'b0);
        chk("b2b_done",   int'(bus.DONE),   0);
        chk("b2b_qready", int'(bus.QREADY), 1);
        chk("b2b_cnt",    int'(bus.CNT),    0);
        drive(1'b0, 0, 9, 1'b1, 1'b0);
        idle();
        chk("b2b_sum",  int'(bus.SUM),  18);
        chk("b2b_done", int'(bus.DONE), 1);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        idle();

        // Mid-frame reset
        drive(1'b1, 4, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1, 1'b1, 1'b0);
        drive(1'b0, 0, 2, 1'b1, 1'b0);
        RES = 1'b1;
        drive(1'b0, 0, 5, 1'b1, 1'b0);
        RES = 1'b0;
        drive(1'b0, 0, 5, 1'b1, 1'b0);
        chk("mrst_sum",    int'(bus.SUM),    0);
        chk("mrst_cnt",    int'(bus.CNT),    0);
        chk("mrst_busy",   int'(bus.BUSY),   0);
        chk("mrst_qready", int'(bus.QREADY), 0);
        drive(1'b0, 0, 5, 1'b1, 1'b0);
        idle();
        chk("mrst_ignored_sum", int'(bus.SUM), 0);
        chk("mrst_ignored_cnt", int'(bus.CNT), 0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
